// File: rtl/load_align_unit.sv
// rtl/load_align_unit.sv - load-data formatter with sub-word extraction and two-beat misaligned loads
// Sits between the data-memory port and writeback; handshakes absorb memory latency and writeback stalls.
module load_align_unit #(
  parameter int XLEN        = 64,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [2:0]                req_funct3,
  input  logic [$clog2(XLEN/8)-1:0] req_offset,
  output logic                      mem_req,
  output logic                      mem_beat,
  input  logic                      mem_rvalid,
  input  logic [XLEN-1:0]           mem_rdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [XLEN-1:0]           rsp_data,
  output logic                      rsp_err
);

  localparam int OW = $clog2(XLEN/8);
  localparam int SW = $clog2(XLEN);
  localparam int NB = XLEN/8;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t          state, state_nx;
  logic [2:0]      f3_q;
  logic [OW-1:0]   off_q;
  logic            cross_q;
  logic [XLEN-1:0] lo_q;

  logic [3:0]      req_size;
  logic            req_cross;
  logic            req_illegal;
  logic            req_fail;

  assign req_size    = 4'd1 << req_funct3[1:0];
  assign req_cross   = (int'(req_offset) + int'(req_size)) > NB;
  assign req_illegal = (req_funct3 == 3'd7) ||
                       ((XLEN == 32) && ((req_funct3 == 3'd3) || (req_funct3 == 3'd6)));
  assign req_fail    = req_illegal || (req_cross && !MISALIGN_EN);

  // In BEAT1 the captured lo word pairs with the incoming hi word; otherwise hi is zero.
  logic [XLEN-1:0] lo_src, hi_src, sh_lo, keep, fmt;
  logic [SW:0]     nbits;
  logic [SW-1:0]   sidx;
  logic            sign;

  assign lo_src = (state == BEAT1) ? lo_q : mem_rdata;
  assign hi_src = (state == BEAT1) ? mem_rdata : '0;
  assign sh_lo  = XLEN'({hi_src, lo_src} >> {off_q, 3'b000});
  assign nbits  = (SW+1)'(8) << f3_q[1:0];
  // A full-width shift wraps to zero, so the subtraction yields an all-ones mask.
  assign keep   = (XLEN'(1) << nbits) - XLEN'(1);
  assign sidx   = SW'(nbits - (SW+1)'(1));
  assign sign   = sh_lo[sidx];
  assign fmt    = (sh_lo & keep) | ((sign && !f3_q[2]) ? ~keep : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    mem_req   = 1'b0;
    mem_beat  = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = req_fail ? RESP : BEAT0;
      end
      BEAT0: begin
        mem_req = 1'b1;
        if (mem_rvalid) state_nx = cross_q ? BEAT1 : RESP;
      end
      BEAT1: begin
        mem_req  = 1'b1;
        mem_beat = 1'b1;
        if (mem_rvalid) state_nx = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_q     <= '0;
      off_q    <= '0;
      cross_q  <= 1'b0;
      lo_q     <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          f3_q    <= req_funct3;
          off_q   <= req_offset;
          cross_q <= req_cross;
          if (req_fail) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        BEAT0: if (mem_rvalid) begin
          lo_q <= mem_rdata;
          if (!cross_q) begin
            rsp_data <= fmt;
            rsp_err  <= 1'b0;
          end
        end
        BEAT1: if (mem_rvalid) begin
          rsp_data <= fmt;
          rsp_err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// tb/tb_load_align_unit.sv - scoreboard bench for load_align_unit
// Instance a has misaligned support, instance b returns errors for word-crossing loads.
module tb_load_align_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [2:0]  req_offset = '0;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        rsp_ready = 1'b0;
  logic        sel = 1'b0;

  logic        a_req_ready, a_mem_req, a_mem_beat, a_rsp_valid, a_rsp_err;
  logic [63:0] a_rsp_data;
  logic        b_req_ready, b_mem_req, b_mem_beat, b_rsp_valid, b_rsp_err;
  logic [63:0] b_rsp_data;

  always #5 clk = ~clk;

  load_align_unit #(.XLEN(64), .MISALIGN_EN(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & ~sel), .req_ready(a_req_ready),
    .req_funct3(req_funct3), .req_offset(req_offset), .mem_req(a_mem_req), .mem_beat(a_mem_beat),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(a_rsp_data), .rsp_err(a_rsp_err)
  );

  load_align_unit #(.XLEN(64), .MISALIGN_EN(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & sel), .req_ready(b_req_ready),
    .req_funct3(req_funct3), .req_offset(req_offset), .mem_req(b_mem_req), .mem_beat(b_mem_beat),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(b_rsp_data), .rsp_err(b_rsp_err)
  );

  logic        m_req_ready, m_mem_req, m_mem_beat, m_rsp_valid, m_rsp_err;
  logic [63:0] m_rsp_data;
  assign m_req_ready = sel ? b_req_ready : a_req_ready;
  assign m_mem_req   = sel ? b_mem_req   : a_mem_req;
  assign m_mem_beat  = sel ? b_mem_beat  : a_mem_beat;
  assign m_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign m_rsp_err   = sel ? b_rsp_err   : a_rsp_err;
  assign m_rsp_data  = sel ? b_rsp_data  : a_rsp_data;

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          lat;
    int          nbeats;
    logic [1:0]  seq;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          rsp_start = 0;
  logic        prev_v = 1'b0;
  logic [63:0] w0 = '0;
  logic [63:0] w1 = '0;
  logic        block_b1 = 1'b0;
  logic        stray = 1'b0;
  int          beat_cnt = 0;
  logic [1:0]  beat_seq = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor first, then the zero-wait memory responder, both on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (m_rsp_valid && !prev_v) rsp_start = cyc;
      prev_v = m_rsp_valid;
      if (m_rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp data=%h err=%0b", m_rsp_data, m_rsp_err);
        end else begin
          e = sb.pop_front();
          chk("rsp_data", m_rsp_data, e.data);
          chk("rsp_err", 64'(m_rsp_err), 64'(e.err));
          chk("latency", 64'(rsp_start - acc_cyc), 64'(e.lat));
          chk("beat_count", 64'(beat_cnt), 64'(e.nbeats));
          chk("beat_order", 64'(beat_seq), 64'(e.seq));
        end
        beat_cnt = 0;
        beat_seq = '0;
      end
      if (stray) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
      end else if (m_mem_req && !(block_b1 && m_mem_beat)) begin
        mem_rvalid = 1'b1;
        mem_rdata  = m_mem_beat ? w1 : w0;
        beat_cnt++;
        beat_seq   = {beat_seq[0], m_mem_beat};
      end else begin
        mem_rvalid = 1'b0;
      end
    end
  end

  task automatic do_req(input logic b, input logic [2:0] f3, input logic [2:0] off,
                        input logic [63:0] a0, input logic [63:0] a1,
                        input logic [63:0] ed, input logic ee, input int lat,
                        input int nb, input logic [1:0] seq, input int hold);
    exp_t e;
    int   n;
    e.data = ed; e.err = ee; e.lat = lat; e.nbeats = nb; e.seq = seq;
    sel = b; w0 = a0; w1 = a1;
    sb.push_back(e);
    req_funct3 = f3;
    req_offset = off;
    req_valid  = 1'b1;
    acc_cyc    = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!m_rsp_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!m_rsp_valid) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout actual=0 required=1 funct3=%0d offset=%0d", f3, off);
      void'(sb.pop_back());
    end else begin
      repeat (hold) begin
        @(negedge clk);
        chk("hold_valid", 64'(m_rsp_valid), 64'd1);
        chk("hold_data", m_rsp_data, ed);
        chk("hold_req_ready", 64'(m_req_ready), 64'd0);
        @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
    end
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_mem_req", 64'(a_mem_req), 64'd0);
    chk("reset_mem_beat", 64'(a_mem_beat), 64'd0);
    chk("reset_rsp_valid", 64'(a_rsp_valid), 64'd0);
    chk("reset_rsp_data", a_rsp_data, 64'd0);
    chk("reset_rsp_err", 64'(a_rsp_err), 64'd0);
    chk("reset_req_ready", 64'(a_req_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_req(0, 3'd0, 3'd7, 64'h8011_2233_4455_6677, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 0, 2, 1, 2'b00, 0);
    do_req(0, 3'd5, 3'd7, 64'h34AA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BB12,
           64'h0000_0000_0000_1234, 0, 3, 2, 2'b01, 0);
    do_req(0, 3'd2, 3'd6, 64'hBEEF_1111_2222_3333, 64'h4444_5555_6666_8DAD,
           64'hFFFF_FFFF_8DAD_BEEF, 0, 3, 2, 2'b01, 0);
    do_req(0, 3'd3, 3'd0, 64'h0123_4567_89AB_CDEF, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 2, 1, 2'b00, 3);
    do_req(0, 3'd7, 3'd0, 64'h0, 64'h0, 64'h0, 1, 1, 0, 2'b00, 0);
    do_req(0, 3'd1, 3'd2, 64'h0000_0000_C3A5_0000, 64'h0, 64'hFFFF_FFFF_FFFF_C3A5, 0, 2, 1, 2'b00, 0);
    do_req(0, 3'd6, 3'd4, 64'h89AB_CDEF_0000_0000, 64'h0, 64'h0000_0000_89AB_CDEF, 0, 2, 1, 2'b00, 0);

    do_req(1, 3'd3, 3'd4, 64'h1111_1111_1111_1111, 64'h0, 64'h0, 1, 1, 0, 2'b00, 0);
    do_req(1, 3'd7, 3'd0, 64'h1111_1111_1111_1111, 64'h0, 64'h0, 1, 1, 0, 2'b00, 0);
    do_req(1, 3'd4, 3'd3, 64'h1122_3344_5566_7788, 64'h0, 64'h0000_0000_0000_0055, 0, 2, 1, 2'b00, 0);
    do_req(1, 3'd2, 3'd6, 64'h1122_3344_5566_7788, 64'h0, 64'h0, 1, 1, 0, 2'b00, 0);

    // Abandon a crossing load in BEAT1 with an asynchronous reset pulse.
    sel = 1'b0; block_b1 = 1'b1;
    w0 = 64'h34AA_AAAA_AAAA_AAAA; w1 = 64'hBBBB_BBBB_BBBB_BB12;
    req_funct3 = 3'd5; req_offset = 3'd7; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!a_mem_beat && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_beat1", 64'(a_mem_beat), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mem_req", 64'(a_mem_req), 64'd0);
    chk("rst_req_ready", 64'(a_req_ready), 64'd1);
    #1 rst_n = 1'b1;
    block_b1 = 1'b0;
    stray = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    stray = 1'b0;
    beat_cnt = 0;
    beat_seq = '0;
    @(negedge clk);
    chk("post_rst_req_ready", 64'(a_req_ready), 64'd1);
    chk("post_rst_mem_req", 64'(a_mem_req), 64'd0);
    chk("post_rst_rsp_valid", 64'(a_rsp_valid), 64'd0);
    @(posedge clk); #1;

    do_req(0, 3'd0, 3'd0, 64'h0000_0000_0000_007F, 64'h0, 64'h0000_0000_0000_007F, 0, 2, 1, 2'b00, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
